periph_bus_router: RTL
======================

Name: periph_bus_router

Overview:
- Registered request router between the control unit and the external/internal data targets. Generalises the combinational peripheral address decoder into N peripheral slots plus the SPI memory path.
- Adds per-slot acknowledge handshakes, a fire-and-forget mode, a bus timeout and decode-error reporting.
- Sits in manquehuito_domain between control_unit and spi_master / memory-mapped peripherals such as ps_pwm_wrapper.

Parameters:
- ADDR_W, 16, request address width
- DATA_W, 8, data byte width
- NUM_SLAVES, 4, peripheral slots, legal range 1..4
- PERIPH_NIBBLE, 4'hF, value of addr[7:4] that selects the peripheral region
- ACK_MASK, 4'b0000, bit s=1: slot s returns periph_ack_i; bit s=0: slot s is fire-and-forget
- TIMEOUT_CYCLES, 255, maximum wait cycles in a wait state; 0 disables the timeout

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- req_start_i  in  1  request pulse from control unit
- req_addr_i  in  ADDR_W  request address
- req_rnw_i  in  1  1=read, 0=write
- req_nbytes_i  in  2  bytes for memory transfer
- req_wdata_i  in  DATA_W  write data
- req_done_o  out  1  one-cycle completion pulse
- req_busy_o  out  1  request in flight
- req_err_o  out  1  valid with req_done_o; 1=timeout or decode error
- req_rdata_o  out  2*DATA_W  read data, valid from req_done_o until next accept
- lat_addr_o  out  ADDR_W  latched address to all targets
- lat_rnw_o  out  1  latched read_not_write
- lat_nbytes_o  out  2  latched byte count
- lat_wdata_o  out  DATA_W  latched write data
- mem_start_o  out  1  one-cycle start to spi_master
- mem_done_i  in  1  spi_master transaction_done
- mem_rdata_i  in  2*DATA_W  {byte2,byte1} from spi_master
- periph_cs_o  out  NUM_SLAVES  one-hot, one-cycle select pulse
- periph_ack_i  in  NUM_SLAVES  per-slot completion
- periph_rdata_i  in  NUM_SLAVES*DATA_W  slot s read data at [s*DATA_W +: DATA_W]

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-low on rst_n_i.
- Reset: state IDLE. All outputs 0, including lat_*, req_rdata_o and the timeout counter.
- Decode on accept:
  - peripheral when req_addr_i[7:4]==PERIPH_NIBBLE; slot = req_addr_i[3:2]; address bits above 7 are ignored for the decode.
  - otherwise memory.
  - slot >= NUM_SLAVES is a decode error.
- States are IDLE, MEM_START, MEM_WAIT, PER_SEL, PER_WAIT and RESP.
- IDLE:
  - On req_start_i, latch all req_* into lat_*, set req_busy_o=1 and go to MEM_START or PER_SEL.
  - A decode error goes to RESP with err=1.
  - A new accept clears req_rdata_o.
- MEM_START: mem_start_o=1 for exactly one cycle, then go to MEM_WAIT.
- MEM_WAIT:
  - On mem_done_i: capture mem_rdata_i into req_rdata_o, go to RESP.
- PER_SEL: periph_cs_o[slot]=1 for exactly one cycle.
  - If ACK_MASK[slot]=0, go to RESP with rdata=0.
  - Otherwise go to PER_WAIT.
- PER_WAIT:
  - On periph_ack_i[slot], req_rdata_o = {DATA_W'0, periph_rdata_i slot}; go to RESP.
  - Acks from other slots are ignored.
- RESP: req_done_o=1 and req_err_o valid for one cycle, req_busy_o drops to 0 next cycle, state returns to IDLE.
- Timeout:
  - The counter clears on entry to MEM_WAIT/PER_WAIT and increments each wait cycle.
  - At count==TIMEOUT_CYCLES with no done/ack: go to RESP with err=1 and rdata=0.
  - A done/ack arriving in the same cycle as the timeout wins (err=0).
- req_start_i while busy (including RESP) is ignored; no queuing.
- mem_done_i or periph_ack_i outside a wait state is ignored.
- Latencies, start accepted at cycle 0:
  - memory: mem_start_o at cycle 1; mem_done_i at cycle k gives req_done_o at k+1.
  - fire-and-forget: cs at 1, done at 2.
  - acked slot: ack at k gives done at k+1.
  - decode error: done at 1.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse is issued. A late mem_done_i after reset is ignored.
- lat_* hold their value until the next accept.

Test Plan:
- Memory read: addr 0x0012, rnw=1, nbytes=2; mem_done_i 5 cycles after mem_start_o with mem_rdata_i=0xBEEF -> mem_start_o one cycle at cycle 1; req_done_o one cycle after mem_done_i; rdata=0xBEEF, err=0.
- Fire-and-forget write, ACK_MASK=0: addr 0x00F4, wdata 0x3C -> periph_cs_o=4'b0010 at cycle 1; done at cycle 2 with err=0; lat_wdata_o=0x3C; mem_start_o never asserted.
- Acked peripheral, ACK_MASK=4'b1000: addr 0x00FC, rnw=1; periph_ack_i[3] after 3 cycles with slice=0xA5, plus a spurious periph_ack_i[0] -> rdata=0x00A5, err=0; spurious ack has no effect.
- Timeout: TIMEOUT_CYCLES=8, memory request, mem_done_i never arrives -> req_done_o with err=1 and rdata=0 after 8 wait cycles. Repeat with mem_done_i in the exact timeout cycle -> err=0.
- Decode error and busy drop: NUM_SLAVES=2, addr 0x00F8 -> done+err at cycle 1, no cs pulse. A second req_start_i issued during MEM_WAIT is ignored (only one mem_start_o).
- Reset mid-MEM_WAIT -> all outputs 0 and state IDLE; a subsequent mem_done_i produces no req_done_o.

Source files
------------

// File: rtl/periph_bus_router.sv
// Registered request router: decodes each accepted request to the SPI memory path or one of
// NUM_SLAVES peripheral slots, with per-slot ack/fire-and-forget, wait timeout and decode errors.
module periph_bus_router #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [3:0]  PERIPH_NIBBLE  = 4'hF,
    parameter logic [3:0]  ACK_MASK       = 4'b0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         req_start_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic                         req_rnw_i,
    input  logic [1:0]                   req_nbytes_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
    output logic                         req_done_o,
    output logic                         req_busy_o,
    output logic                         req_err_o,
    output logic [2*DATA_W-1:0]          req_rdata_o,
    output logic [ADDR_W-1:0]            lat_addr_o,
    output logic                         lat_rnw_o,
    output logic [1:0]                   lat_nbytes_o,
    output logic [DATA_W-1:0]            lat_wdata_o,
    output logic                         mem_start_o,
    input  logic                         mem_done_i,
    input  logic [2*DATA_W-1:0]          mem_rdata_i,
    output logic [NUM_SLAVES-1:0]        periph_cs_o,
    input  logic [NUM_SLAVES-1:0]        periph_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] periph_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // The wait state times out in the cycle whose increment would reach TIMEOUT_CYCLES,
    // so a wait state lasts at most TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MEM_START,
        MEM_WAIT,
        PER_SEL,
        PER_WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic                lat_rnw_q, lat_rnw_d;
    logic [1:0]          lat_nbytes_q, lat_nbytes_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [1:0]          slot_q, slot_d;
    logic                err_q, err_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]            acc_slot;
    logic                  acc_is_per;
    logic                  acc_dec_err;
    logic [NUM_SLAVES-1:0] slot_sel;
    logic                  ack_hit;
    logic                  ack_en;
    logic                  timeout_hit;
    logic [DATA_W-1:0]     slot_rdata;

    always_comb begin
        acc_slot    = req_addr_i[3:2];
        acc_is_per  = (req_addr_i[7:4] == PERIPH_NIBBLE);
        acc_dec_err = acc_is_per && (32'(acc_slot) >= NUM_SLAVES);
        slot_sel    = NUM_SLAVES'(1) << slot_q;
        ack_hit     = |(periph_ack_i & slot_sel);
        ack_en      = |(ACK_MASK[NUM_SLAVES-1:0] & slot_sel);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
        slot_rdata  = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (32'(slot_q) == s) begin
                slot_rdata = periph_rdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            lat_addr_q   <= '0;
            lat_rnw_q    <= 1'b0;
            lat_nbytes_q <= '0;
            lat_wdata_q  <= '0;
            slot_q       <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lat_addr_q   <= lat_addr_d;
            lat_rnw_q    <= lat_rnw_d;
            lat_nbytes_q <= lat_nbytes_d;
            lat_wdata_q  <= lat_wdata_d;
            slot_q       <= slot_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_addr_d   = lat_addr_q;
        lat_rnw_d    = lat_rnw_q;
        lat_nbytes_d = lat_nbytes_q;
        lat_wdata_d  = lat_wdata_q;
        slot_d       = slot_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_start_i) begin
                    lat_addr_d   = req_addr_i;
                    lat_rnw_d    = req_rnw_i;
                    lat_nbytes_d = req_nbytes_i;
                    lat_wdata_d  = req_wdata_i;
                    slot_d       = acc_slot;
                    err_d        = acc_dec_err;
                    rdata_d      = '0;
                    cnt_d        = '0;
                    if (acc_dec_err) begin
                        state_d = RESP;
                    end else if (acc_is_per) begin
                        state_d = PER_SEL;
                    end else begin
                        state_d = MEM_START;
                    end
                end
            end
            MEM_START: begin
                cnt_d   = '0;
                state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_done_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PER_SEL: begin
                cnt_d   = '0;
                state_d = ack_en ? PER_WAIT : RESP;
            end
            PER_WAIT: begin
                if (ack_hit) begin
                    rdata_d = {{DATA_W{1'b0}}, slot_rdata};
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_start_o = (state_q == MEM_START);
        periph_cs_o = (state_q == PER_SEL) ? slot_sel : '0;
        req_done_o  = (state_q == RESP);
        req_err_o   = (state_q == RESP) && err_q;
        req_busy_o  = (state_q != IDLE);
    end

    assign req_rdata_o  = rdata_q;
    assign lat_addr_o   = lat_addr_q;
    assign lat_rnw_o    = lat_rnw_q;
    assign lat_nbytes_o = lat_nbytes_q;
    assign lat_wdata_o  = lat_wdata_q;

endmodule
